mfp_ahb_loader_master: RTL and testbench
========================================

Name: mfp_ahb_loader_master

Overview:
- Next-generation serial-load bus master for the MFP AHB-Lite fabric.
- Accepts byte writes from the SREC parser into a coalescing stage and a FIFO of depth FIFO_DEPTH.
- Issues HREADY-aware AHB-Lite word, halfword or byte writes.
- Owns the downstream bus while loading and until fully drained; CPU master signals pass through otherwise.

Parameters:
- FIFO_DEPTH, 8, coalesced-entry FIFO depth (power of 2, 2..64).
- FLUSH_CYCLES, 16, idle cycles after the last byte before a partial word is flushed.
- CNT_W, 16, width of the issued-transfer counter.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  synchronous active-high reset.
- big_endian  in  1  byte-lane order, same meaning as SI_Endian.
- load_active  in  1  parser in_progress.
- wr_addr  in  32  parser byte address.
- wr_byte  in  8  parser byte.
- wr_en  in  1  one-cycle byte strobe; no backpressure.
- cpu_HADDR / cpu_HBURST / cpu_HMASTLOCK / cpu_HPROT / cpu_HSIZE / cpu_HTRANS / cpu_HWDATA / cpu_HWRITE  in  32/3/1/4/3/2/32/1  CPU master signals.
- HREADY  in  1  bus ready from the slave mux.
- HADDR / HBURST / HMASTLOCK / HPROT / HSIZE / HTRANS / HWDATA / HWRITE  out  32/3/1/4/3/2/32/1  muxed bus.
- loader_busy  out  1  loader owns the bus; holds the CPU in reset.
- overflow_err  out  1  sticky flag: a byte was dropped.
- xfer_count  out  CNT_W  AHB write transfers issued; saturating.

Behaviour:
- Reset values:
  - loader_busy=0, overflow_err=0, xfer_count=0.
  - Coalescer and FIFO empty; FSM in IDLE.
  - Bus outputs follow the cpu_* inputs.
- Ownership:
  - loader_busy = load_active | coalescer valid | FIFO not empty | FSM != IDLE.
  - While loader_busy=1, all bus outputs come from the loader:
    - HBURST=SINGLE, HMASTLOCK=0, HPROT=4'b0011, HWRITE=1.
    - HTRANS=IDLE except in an address phase.
- Coalescer: holds word address A[31:2], 4-bit mask (indexed by byte offset) and 32-bit data.
  - On wr_en with the same A: set the mask bit and store the byte.
  - Byte lane = offset when little-endian, 3-offset when big-endian.
  - Flush into the FIFO on any of:
    - wr_en with a different A (flush, then the new byte starts a new word in the same cycle);
    - mask==4'hF;
    - FLUSH_CYCLES cycles with no wr_en;
    - load_active falling.
- Overflow: if a flush is needed while the FIFO is full, discard the entry, set overflow_err, and still accept the new byte.
- Master FSM:
  - States:
    - IDLE;
    - ADDR (HTRANS=NONSEQ, HADDR/HSIZE valid);
    - DATA (HTRANS=IDLE, HWDATA valid).
  - IDLE->ADDR: FIFO head has pending lanes, HREADY=1, and loader_busy was already 1 in the previous cycle (one-cycle guard after takeover).
  - ADDR->DATA: HREADY=1.
  - DATA: when HREADY=1, increment xfer_count and clear the issued lanes.
    - If head lanes are all done, pop the FIFO.
    - Go to ADDR if work remains, else IDLE.
  - Minimum 2 cycles per transfer.
- Transfer selection per FIFO entry:
  - mask F: one word write (HSIZE=2, HADDR={A,2'b00}).
  - mask 0011 or 1100 remaining: halfword write (HSIZE=1, offset 0 or 2).
  - Otherwise single byte writes (HSIZE=0) in ascending offset order.
  - A mask of 0111 yields a halfword at offset 0, then a byte at offset 2.
- HWDATA: entry data on its endian lanes; lanes not written are don't-care (driven 0).
- Release: when load_active=0, the coalescer is empty, the FIFO is empty and the FSM is IDLE, loader_busy drops; the CPU passes through from the next cycle.
- Simultaneous events:
  - Flush and FIFO pop in the same cycle with the FIFO full: the push succeeds, no overflow.
  - wr_en together with load_active falling: the byte is accepted, then flushed.
- HRESET mid-transfer: everything is abandoned immediately and outputs return to reset values; no completion guarantee.

Decomposition:
- Shared package mfp_ahb_loader_pkg:
  - HTRANS/HSIZE/HBURST encodings;
  - FSM state enum;
  - FIFO entry struct {addr[31:2], mask[3:0], data[31:0]}.
- One sub-module: mfp_loader_fifo, a synchronous FIFO with push/pop/full/empty, parametrised by depth and width.

Test Plan:
- Little-endian: bytes 0x11,0x22,0x33,0x44 to 0x0000_0100..0x103, load_active then low -> one NONSEQ word write at 0x100, HSIZE=2, HWDATA=0x44332211, xfer_count=1, loader_busy drops after the data phase.
- Big-endian: same bytes -> HWDATA=0x11223344.
- Bytes to 0x200, 0x201, 0x202, then a FLUSH_CYCLES gap -> halfword write at 0x200 (HWDATA[15:0]=0x2211 LE), then a byte write at 0x202, xfer_count=2.
- HREADY held low for 5 cycles in ADDR -> HADDR/HSIZE/HTRANS stable; HWDATA presented only after HREADY; count increments once.
- 9 full words with HREADY=0 throughout, FIFO_DEPTH=8 -> overflow_err=1 once the 9th word's flush finds the FIFO full; after HREADY=1, exactly 8 words are written.
- HRESET asserted in DATA -> next cycle HTRANS=IDLE, bus follows cpu_*, loader_busy=0, xfer_count=0.

Source files
------------

// File: rtl/mfp_ahb_loader_pkg.sv
// mfp_ahb_loader_pkg: shared AHB encodings, FSM states, FIFO entry type and lane helper
package mfp_ahb_loader_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [3:0] HPROT_LOADER  = 4'b0011;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } entry_t;
  function automatic logic [31:0] place_lanes(input logic [31:0] data, input logic [3:0] lanes, input logic be);
    logic [31:0] r;
    r = '0;
    for (int o = 0; o < 4; o++)
      if (lanes[o]) r[8*(be ? 3-o : o) +: 8] = data[8*o +: 8];
    return r;
  endfunction
endpackage

// File: rtl/mfp_loader_fifo.sv
// mfp_loader_fifo: synchronous FIFO with push/pop/full/empty, simultaneous push+pop allowed when full
module mfp_loader_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 66
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;
  always_comb begin
    empty   = wr_q == rd_q;
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    count   = wr_q - rd_q;
    dout    = mem_q[rd_q[AW-1:0]];
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mfp_ahb_loader_master.sv
// mfp_ahb_loader_master: coalescing serial-load AHB-Lite write master with CPU pass-through
module mfp_ahb_loader_master
  import mfp_ahb_loader_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             big_endian,
  input  logic             load_active,
  input  logic [31:0]      wr_addr,
  input  logic [7:0]       wr_byte,
  input  logic             wr_en,
  input  logic [31:0]      cpu_HADDR,
  input  logic [2:0]       cpu_HBURST,
  input  logic             cpu_HMASTLOCK,
  input  logic [3:0]       cpu_HPROT,
  input  logic [2:0]       cpu_HSIZE,
  input  logic [1:0]       cpu_HTRANS,
  input  logic [31:0]      cpu_HWDATA,
  input  logic             cpu_HWRITE,
  input  logic             HREADY,
  output logic [31:0]      HADDR,
  output logic [2:0]       HBURST,
  output logic             HMASTLOCK,
  output logic [3:0]       HPROT,
  output logic [2:0]       HSIZE,
  output logic [1:0]       HTRANS,
  output logic [31:0]      HWDATA,
  output logic             HWRITE,
  output logic             loader_busy,
  output logic             overflow_err,
  output logic [CNT_W-1:0] xfer_count
);
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic             co_valid_q, co_valid_d;
  logic [29:0]      co_addr_q, co_addr_d;
  logic [3:0]       co_mask_q, co_mask_d;
  logic [31:0]      co_data_q, co_data_d;
  logic [IW-1:0]    idle_q, idle_d;
  state_t           state_q, state_d;
  logic [3:0]       done_q, done_d;
  logic             busy_prev_q;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           head, push_entry;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic             timeout, flush, push_ok, pop, complete, all_done;
  logic [3:0]       rem, sel_lanes, new_done;
  logic [1:0]       lo;
  logic [2:0]       sel_size;
  mfp_loader_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
    .clk(HCLK), .rst(HRESET), .push(push_ok), .pop(pop), .din(push_entry),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    timeout    = co_valid_q && !wr_en && idle_q == IW'(FLUSH_CYCLES - 1);
    flush      = co_valid_q && (co_mask_q == 4'hF || !load_active || timeout || (wr_en && wr_addr[31:2] != co_addr_q));
    push_entry = {co_addr_q, co_mask_q, co_data_q};
    co_valid_d = co_valid_q && !flush;
    co_addr_d  = co_addr_q;
    co_mask_d  = flush ? 4'h0 : co_mask_q;
    co_data_d  = flush ? 32'h0 : co_data_q;
    idle_d     = (wr_en || !co_valid_q) ? '0 : idle_q + 1'b1;
    if (wr_en) begin
      co_valid_d                       = 1'b1;
      co_addr_d                        = wr_addr[31:2];
      co_mask_d[wr_addr[1:0]]          = 1'b1;
      co_data_d[8*wr_addr[1:0] +: 8]   = wr_byte;
    end
  end
  always_comb begin
    rem       = empty ? 4'h0 : head.mask & ~done_q;
    lo        = rem[0] ? 2'd0 : rem[1] ? 2'd1 : rem[2] ? 2'd2 : 2'd3;
    sel_lanes = rem == 4'hF ? 4'hF : rem[1:0] == 2'b11 ? 4'h3 : rem == 4'hC ? 4'hC : 4'b0001 << lo;
    sel_size  = rem == 4'hF ? HSIZE_WORD : (sel_lanes == 4'h3 || sel_lanes == 4'hC) ? HSIZE_HALF : HSIZE_BYTE;
    new_done  = done_q | sel_lanes;
    all_done  = (head.mask & ~new_done) == 4'h0;
    complete  = state_q == ST_DATA && HREADY;
    pop       = complete && all_done;
    push_ok   = flush && (!full || pop);
    done_d    = complete ? (all_done ? 4'h0 : new_done) : done_q;
    cnt_d     = (complete && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    ovf_d     = ovf_q || (flush && !push_ok);
    state_d   = state_q;
    case (state_q)
      ST_IDLE: state_d = (rem != 4'h0 && HREADY && busy_prev_q) ? ST_ADDR : ST_IDLE;
      ST_ADDR: state_d = HREADY ? ST_DATA : ST_ADDR;
      ST_DATA: state_d = !HREADY ? ST_DATA : (!all_done || count > CW'(1) || push_ok) ? ST_ADDR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      co_valid_q  <= 1'b0;
      co_addr_q   <= '0;
      co_mask_q   <= '0;
      co_data_q   <= '0;
      idle_q      <= '0;
      state_q     <= ST_IDLE;
      done_q      <= '0;
      busy_prev_q <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      co_valid_q  <= co_valid_d;
      co_addr_q   <= co_addr_d;
      co_mask_q   <= co_mask_d;
      co_data_q   <= co_data_d;
      idle_q      <= idle_d;
      state_q     <= state_d;
      done_q      <= done_d;
      busy_prev_q <= loader_busy;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end
  always_comb begin
    loader_busy  = load_active || co_valid_q || !empty || state_q != ST_IDLE;
    overflow_err = ovf_q;
    xfer_count   = cnt_q;
    HADDR        = loader_busy ? (state_q == ST_ADDR ? {head.addr, lo} : 32'h0) : cpu_HADDR;
    HSIZE        = loader_busy ? (state_q == ST_ADDR ? sel_size : HSIZE_BYTE) : cpu_HSIZE;
    HTRANS       = loader_busy ? (state_q == ST_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE) : cpu_HTRANS;
    HWDATA       = loader_busy ? (state_q == ST_DATA ? place_lanes(head.data, sel_lanes, big_endian) : 32'h0) : cpu_HWDATA;
    HBURST       = loader_busy ? HBURST_SINGLE : cpu_HBURST;
    HMASTLOCK    = loader_busy ? 1'b0 : cpu_HMASTLOCK;
    HPROT        = loader_busy ? HPROT_LOADER : cpu_HPROT;
    HWRITE       = loader_busy ? 1'b1 : cpu_HWRITE;
  end
endmodule

// File: tb/tb_mfp_ahb_loader_master.sv
// tb_mfp_ahb_loader_master: scoreboard bench with a word-level reference model of the loader
module tb_mfp_ahb_loader_master;
  localparam int FC = 16;
  logic        HCLK = 1'b0, HRESET = 1'b1, big_endian = 1'b0, load_active = 1'b0, wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [7:0]  wr_byte = '0;
  logic [31:0] cpu_HADDR = '0, cpu_HWDATA = '0;
  logic [2:0]  cpu_HBURST = '0, cpu_HSIZE = '0;
  logic        cpu_HMASTLOCK = 1'b0, cpu_HWRITE = 1'b0;
  logic [3:0]  cpu_HPROT = '0;
  logic [1:0]  cpu_HTRANS = '0;
  logic        HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, loader_busy, overflow_err;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [15:0] xfer_count;
  int          hr_mode = 1;
  logic        hr_rnd = 1'b1;
  typedef struct {logic [31:0] addr; logic [2:0] size; logic [31:0] data;} xfer_t;
  xfer_t exp_q[$];
  int n_chk = 0, n_pass = 0, exp_total = 0;
  logic        dpend = 1'b0, stalled = 1'b0;
  logic [31:0] st_addr, cur_addr;
  logic [2:0]  st_size, cur_size;

  mfp_ahb_loader_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .big_endian(big_endian), .load_active(load_active),
    .wr_addr(wr_addr), .wr_byte(wr_byte), .wr_en(wr_en),
    .cpu_HADDR(cpu_HADDR), .cpu_HBURST(cpu_HBURST), .cpu_HMASTLOCK(cpu_HMASTLOCK), .cpu_HPROT(cpu_HPROT),
    .cpu_HSIZE(cpu_HSIZE), .cpu_HTRANS(cpu_HTRANS), .cpu_HWDATA(cpu_HWDATA), .cpu_HWRITE(cpu_HWRITE),
    .HREADY(HREADY), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .loader_busy(loader_busy), .overflow_err(overflow_err), .xfer_count(xfer_count)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) hr_rnd <= ($urandom % 3) != 0;
  assign HREADY = hr_mode == 2 ? hr_rnd : hr_mode == 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, wanted %h", name, act, req);
  endtask

  // reference: split a word's written-byte mask into AHB transfers
  task automatic expect_word(input logic [31:0] a, input logic [3:0] mask, input logic [31:0] bytes, input logic be);
    logic [3:0] m, lanes;
    xfer_t x;
    int off;
    m = mask;
    while (m != 4'h0) begin
      if (m == 4'hF) begin lanes = 4'hF; x.size = 3'd2; end
      else if (m[1:0] == 2'b11) begin lanes = 4'h3; x.size = 3'd1; end
      else if (m == 4'hC) begin lanes = 4'hC; x.size = 3'd1; end
      else begin lanes = m & (~m + 4'd1); x.size = 3'd0; end
      off = 0;
      while (!lanes[off]) off++;
      x.addr = {a[31:2], 2'b00} + off;
      x.data = '0;
      for (int o = 0; o < 4; o++)
        if (lanes[o]) x.data[8*(be ? 3-o : o) +: 8] = bytes[8*o +: 8];
      exp_q.push_back(x);
      exp_total++;
      m = m & ~lanes;
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.size = s; x.data = d;
    exp_q.push_back(x);
    exp_total++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  task automatic write_byte(input logic [31:0] a, input logic [7:0] b);
    wr_addr = a; wr_byte = b; wr_en = 1'b1;
    @(posedge HCLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [3:0] mask, input logic [31:0] bytes);
    for (int o = 0; o < 4; o++)
      if (mask[o]) write_byte({a[31:2], 2'(o)}, bytes[8*o +: 8]);
  endtask

  task automatic drain();
    load_active = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge HCLK); #1;
      if (!loader_busy) break;
    end
    chk("drain_busy", {31'b0, loader_busy}, 32'd0);
    chk("xfer_count", {16'b0, xfer_count}, exp_total);
    chk("exp_left", exp_q.size(), 32'd0);
  endtask

  task automatic check_passthrough();
    cpu_HADDR = $urandom; cpu_HWDATA = $urandom; cpu_HTRANS = 2'($urandom);
    cpu_HSIZE = 3'($urandom); cpu_HPROT = 4'($urandom); cpu_HWRITE = 1'($urandom);
    #1;
    chk("pass_haddr", HADDR, cpu_HADDR);
    chk("pass_ctrl", {HTRANS, HSIZE, HPROT, HWRITE, HWDATA[19:0]},
        {cpu_HTRANS, cpu_HSIZE, cpu_HPROT, cpu_HWRITE, cpu_HWDATA[19:0]});
  endtask

  task automatic wait_addr();
    for (int k = 0; k < 200; k++) begin
      @(posedge HCLK); #1;
      if (HTRANS == 2'b10) break;
    end
    chk("addr_phase_seen", {30'b0, HTRANS}, 32'd2);
  endtask

  always @(negedge HCLK) begin
    xfer_t e;
    if (HRESET) begin
      dpend = 1'b0; stalled = 1'b0;
    end else begin
      if (dpend && HREADY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL xfer_unexpected: got write at %h, wanted none", cur_addr);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_addr", cur_addr, e.addr);
          chk("xfer_size", {29'b0, cur_size}, {29'b0, e.size});
          chk("xfer_data", HWDATA, e.data);
        end
        dpend = 1'b0;
      end
      if (loader_busy && HTRANS == 2'b10) begin
        chk("addr_ctrl", {24'b0, HWRITE, HPROT, HBURST, HMASTLOCK}, {24'b0, 1'b1, 4'b0011, 3'b000, 1'b0});
        if (stalled) begin
          chk("stall_haddr", HADDR, st_addr);
          chk("stall_hsize", {29'b0, HSIZE}, {29'b0, st_size});
        end
        if (HREADY) begin
          cur_addr = HADDR; cur_size = HSIZE; dpend = 1'b1; stalled = 1'b0;
        end else begin
          st_addr = HADDR; st_size = HSIZE; stalled = 1'b1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, bytes;
    logic [3:0]  mask;
    int nw;
    check_passthrough();
    idle(3);
    HRESET = 1'b0;
    idle(1);
    chk("rst_busy", {31'b0, loader_busy}, 32'd0);
    chk("rst_ovf", {31'b0, overflow_err}, 32'd0);
    chk("rst_cnt", {16'b0, xfer_count}, 32'd0);
    check_passthrough();

    big_endian = 1'b0; load_active = 1'b1; hr_mode = 1;
    push_exp(32'h100, 3'd2, 32'h44332211);
    write_word(32'h100, 4'hF, 32'h44332211);
    drain();

    big_endian = 1'b1; load_active = 1'b1;
    push_exp(32'h100, 3'd2, 32'h11223344);
    write_word(32'h100, 4'hF, 32'h44332211);
    drain();

    big_endian = 1'b0; load_active = 1'b1;
    push_exp(32'h200, 3'd1, 32'h00002211);
    push_exp(32'h202, 3'd0, 32'h00330000);
    write_word(32'h200, 4'h7, 32'h00332211);
    idle(FC + 30);
    chk("timeout_flush_cnt", {16'b0, xfer_count}, exp_total);
    drain();

    load_active = 1'b1;
    expect_word(32'h300, 4'hF, 32'hAABBCCDD, 1'b0);
    write_word(32'h300, 4'hF, 32'hAABBCCDD);
    wait_addr();
    hr_mode = 0;
    idle(5);
    chk("stall_no_count", {16'b0, xfer_count}, exp_total - 1);
    hr_mode = 1;
    drain();

    for (int s = 0; s < 20; s++) begin
      big_endian = 1'($urandom);
      load_active = 1'b1;
      hr_mode = 2;
      nw = 1 + $urandom % 6;
      base = $urandom & 32'h0FFF_FFF0;
      for (int w = 0; w < nw; w++) begin
        mask = 4'(1 + $urandom % 15);
        bytes = $urandom;
        expect_word(base + 4 * w, mask, bytes, big_endian);
        write_word(base + 4 * w, mask, bytes);
        idle(($urandom % 8 == 0) ? FC + 2 : $urandom % 3);
      end
      drain();
      check_passthrough();
    end

    hr_mode = 1; big_endian = 1'b0; load_active = 1'b1;
    write_word(32'h400, 4'hF, 32'h01020304);
    wait_addr();
    idle(1);
    hr_mode = 0;
    idle(1);
    chk("in_data_busy", {31'b0, loader_busy}, 32'd1);
    chk("in_data_htrans", {30'b0, HTRANS}, 32'd0);
    cpu_HTRANS = 2'b00; cpu_HADDR = $urandom;
    HRESET = 1'b1; load_active = 1'b0;
    idle(1);
    chk("mid_rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("mid_rst_haddr", HADDR, cpu_HADDR);
    chk("mid_rst_busy", {31'b0, loader_busy}, 32'd0);
    chk("mid_rst_cnt", {16'b0, xfer_count}, 32'd0);
    HRESET = 1'b0;
    exp_q.delete();
    exp_total = 0;
    idle(1);

    load_active = 1'b1;
    for (int w = 0; w < 8; w++) begin
      bytes = $urandom;
      expect_word(32'h1000 + 4 * w, 4'hF, bytes, 1'b0);
      write_word(32'h1000 + 4 * w, 4'hF, bytes);
    end
    idle(3);
    chk("ovf_before", {31'b0, overflow_err}, 32'd0);
    write_word(32'h1020, 4'hF, 32'hDEADBEEF);
    idle(3);
    chk("ovf_after", {31'b0, overflow_err}, 32'd1);
    hr_mode = 1;
    drain();
    chk("ovf_sticky", {31'b0, overflow_err}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
